// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: types shared by the ff_bank RTL and its testbench.
//   ff_mode_t  global flip-flop mode: 00 SR, 01 JK, 10 D, 11 T
package ff_bank_pkg;

   typedef enum logic [1:0] {
      FF_SR = 2'b00,
      FF_JK = 2'b01,
      FF_D  = 2'b10,
      FF_T  = 2'b11
   } ff_mode_t;

endpackage

// File: rtl/ff_bank_if.sv
// ff_bank_if: control/data bundle of the ff_bank flip-flop bank.
//   mode      ff_mode_t, global for all channels
//   a, b      S/J/D/T and R/K inputs per channel
//   load      parallel load strobe, load_val is the value loaded
//   q, qb     flip-flop state and its complement
//   tick_disp slow square wave, toggles on each prescaler tick
//   invalid   sticky SR-forbidden flags (zero unless SRFF_INVALID_FLAG_EN)
// Modports: master drives the inputs, slave is the ff_bank side.
interface ff_bank_if #(
   parameter int unsigned CHANNELS = 4
) ();
   import ff_bank_pkg::*;

   ff_mode_t            mode;
   logic [CHANNELS-1:0] a;
   logic [CHANNELS-1:0] b;
   logic                load;
   logic [CHANNELS-1:0] load_val;
   logic [CHANNELS-1:0] q;
   logic [CHANNELS-1:0] qb;
   logic                tick_disp;
   logic [CHANNELS-1:0] invalid;

   modport master (
      output mode, a, b, load, load_val,
      input  q, qb, tick_disp, invalid
   );

   modport slave (
      input  mode, a, b, load, load_val,
      output q, qb, tick_disp, invalid
   );

endinterface

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every DIV clocks plus a
// display toggle that inverts on every tick.
//   clk        system clock
//   rst        synchronous active-high reset
//   tick       high for the cycle in which the counter holds DIV-1
//   tick_disp  square wave with period 2*DIV clocks
module tick_gen #(
   parameter int unsigned DIV = 70_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick,
   output logic tick_disp
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic             tick_disp_q;

   // Decoded straight from the counter so the first tick lands on the
   // DIV-th cycle after reset release (every cycle when DIV=1).
   assign tick      = (count_q == CNT_MAX);
   assign tick_disp = tick_disp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q     <= '0;
         tick_disp_q <= 1'b0;
      end else begin
         count_q <= tick ? '0 : count_q + 1'b1;
         if (tick) begin
            tick_disp_q <= ~tick_disp_q;
         end
      end
   end

endmodule

// File: rtl/ff_bank.sv
// ff_bank: bank of CHANNELS mode-selectable flip-flops (SR/JK/D/T) that
// update only on prescaler ticks.
//   clk   system clock, all state on posedge
//   rst   synchronous active-high reset, overrides everything
//   bus   ff_bank_if.slave: mode, a, b, load, load_val in;
//         q, qb, tick_disp, invalid out
// Priority per edge: rst > load > tick update > hold.
// Optional macro SRFF_INVALID_FLAG_EN: builds sticky per-channel flags set
// by SR 11 at a tick, cleared by rst or load; otherwise invalid is 0.
module ff_bank
   import ff_bank_pkg::*;
#(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned DIV      = 70_000_000
) (
   input logic   clk,
   input logic   rst,
   ff_bank_if.slave bus
);

   logic                tick;
   logic                tick_disp;
   logic [CHANNELS-1:0] q_q;
   logic [CHANNELS-1:0] q_d;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .tick_disp (tick_disp)
   );

   assign bus.tick_disp = tick_disp;
   assign bus.q         = q_q;
   assign bus.qb        = ~q_q;

`ifdef SRFF_INVALID_FLAG_EN
   logic [CHANNELS-1:0] invalid_q;
   logic [CHANNELS-1:0] invalid_d;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic q_nxt;

      always_comb begin
         q_nxt = q_q[i];
         if (bus.load) begin
            q_nxt = bus.load_val[i];
         end else if (tick) begin
            unique case (bus.mode)
               FF_SR: begin
                  // 11 is forbidden and simply holds
                  case ({bus.a[i], bus.b[i]})
                     2'b01:   q_nxt = 1'b0;
                     2'b10:   q_nxt = 1'b1;
                     default: q_nxt = q_q[i];
                  endcase
               end
               FF_JK: begin
                  case ({bus.a[i], bus.b[i]})
                     2'b01:   q_nxt = 1'b0;
                     2'b10:   q_nxt = 1'b1;
                     2'b11:   q_nxt = ~q_q[i];
                     default: q_nxt = q_q[i];
                  endcase
               end
               FF_D: q_nxt = bus.a[i];
               FF_T: q_nxt = bus.a[i] ? ~q_q[i] : q_q[i];
            endcase
         end
      end

      assign q_d[i] = q_nxt;

`ifdef SRFF_INVALID_FLAG_EN
      logic inv_nxt;

      always_comb begin
         inv_nxt = invalid_q[i];
         if (bus.load) begin
            inv_nxt = 1'b0;
         end else if (tick && (bus.mode == FF_SR) && bus.a[i] && bus.b[i]) begin
            inv_nxt = 1'b1;
         end
      end

      assign invalid_d[i] = inv_nxt;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

`ifdef SRFF_INVALID_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         invalid_q <= '0;
      end else begin
         invalid_q <= invalid_d;
      end
   end

   assign bus.invalid = invalid_q;
`else
   assign bus.invalid = '0;
`endif

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: directed self-checking bench for ff_bank.
// Main DUT: CHANNELS=4, DIV=4. Second DUT: DIV=1, T mode on channel 0.
module tb_ff_bank;
   import ff_bank_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   ff_bank_if #(.CHANNELS(4)) bus ();
   ff_bank_if #(.CHANNELS(4)) bus1 ();

   ff_bank #(
      .CHANNELS (4),
      .DIV      (4)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   ff_bank #(
      .CHANNELS (4),
      .DIV      (1)
   ) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   always #5 clk = ~clk;

`ifdef SRFF_INVALID_FLAG_EN
   localparam logic [3:0] INV_EXP = 4'b0011;
`else
   localparam logic [3:0] INV_EXP = 4'b0000;
`endif

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until tick_disp toggles (i.e. a tick edge just happened).
   task automatic wait_tick(output int cycles);
      logic prev;
      prev   = bus.tick_disp;
      cycles = -1;
      for (int k = 1; k <= 16; k++) begin
         step();
         if (bus.tick_disp !== prev) begin
            cycles = k;
            break;
         end
      end
      if (cycles < 0) check("tick_timeout", 32'(cycles), 32'd4);
   endtask

   int n;

   initial begin
      bus.mode      = FF_SR;
      bus.a         = 4'b0101;
      bus.b         = 4'b0010;
      bus.load      = 1'b0;
      bus.load_val  = 4'b0000;
      bus1.mode     = FF_T;
      bus1.a        = 4'b0001;
      bus1.b        = 4'b0000;
      bus1.load     = 1'b0;
      bus1.load_val = 4'b0000;

      step();
      step();
      check("rst_q", 32'(bus.q), 32'h0);
      check("rst_qb", 32'(bus.qb), 32'hf);
      check("rst_tick_disp", 32'(bus.tick_disp), 32'h0);
      check("rst_invalid", 32'(bus.invalid), 32'h0);
      rst = 1'b0;

      // SR set/reset
      wait_tick(n);
      check("first_tick_latency", 32'(n), 32'd4);
      check("sr_set", 32'(bus.q), 32'b0101);
      check("tick_disp_1", 32'(bus.tick_disp), 32'h1);
      bus.a = 4'b0000;
      bus.b = 4'b0001;
      step();
      check("sr_between_ticks", 32'(bus.q), 32'b0101);
      wait_tick(n);
      check("sr_reset", 32'(bus.q), 32'b0100);
      check("sr_qb", 32'(bus.qb), 32'b1011);

      // SR forbidden: q holds, flag set only with the macro
      bus.a = 4'b0011;
      bus.b = 4'b0011;
      wait_tick(n);
      check("sr_forbidden_hold", 32'(bus.q), 32'b0100);
      check("sr_invalid_set", 32'(bus.invalid), 32'(INV_EXP));
      bus.a = 4'b0000;
      bus.b = 4'b0000;
      wait_tick(n);
      check("sr_invalid_sticky", 32'(bus.invalid), 32'(INV_EXP));
      bus.load     = 1'b1;
      bus.load_val = 4'b0000;
      step();
      bus.load = 1'b0;
      check("load_clr_q", 32'(bus.q), 32'b0000);
      check("load_clr_invalid", 32'(bus.invalid), 32'h0);

      // JK toggle twice
      bus.mode = FF_JK;
      bus.a    = 4'b1111;
      bus.b    = 4'b1111;
      wait_tick(n);
      check("jk_toggle_1", 32'(bus.q), 32'b1111);
      wait_tick(n);
      check("jk_toggle_2", 32'(bus.q), 32'b0000);

      // T mode
      bus.mode = FF_T;
      bus.a    = 4'b1010;
      bus.b    = 4'b0101;
      wait_tick(n);
      check("t_toggle", 32'(bus.q), 32'b1010);
      check("t_invalid_clear", 32'(bus.invalid), 32'h0);

      // D mode
      bus.mode = FF_D;
      bus.a    = 4'b0110;
      wait_tick(n);
      check("d_capture", 32'(bus.q), 32'b0110);

      // Load coinciding with a tick wins over the D update
      bus.a        = 4'b1111;
      bus.load     = 1'b1;
      bus.load_val = 4'b1001;
      wait_tick(n);
      check("load_over_tick", 32'(bus.q), 32'b1001);
      bus.load = 1'b0;

      // Reset beats load
      bus.load     = 1'b1;
      bus.load_val = 4'b1111;
      rst          = 1'b1;
      step();
      check("rst_over_load_q", 32'(bus.q), 32'b0000);
      check("rst_over_load_qb", 32'(bus.qb), 32'b1111);
      check("rst_over_load_disp", 32'(bus.tick_disp), 32'h0);
      check("div1_rst_q", 32'(bus1.q), 32'b0000);
      bus.load = 1'b0;
      rst      = 1'b0;

      // DIV=1: q[0] and tick_disp toggle every clock
      for (int k = 1; k <= 4; k++) begin
         step();
         check("div1_q", 32'(bus1.q), (k % 2 == 1) ? 32'b0001 : 32'b0000);
         check("div1_tick_disp", 32'(bus1.tick_disp), (k % 2 == 1) ? 32'h1 : 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
